// File: rtl/uart_bus_loader.sv
// UART boot loader: receives framed commands on a serial line, writes 32-bit words
// through a bus host port and controls the core-hold line.
module uart_bus_loader #(
    parameter int unsigned ClockFrequency = 50_000_000,
    parameter int unsigned BaudRate       = 115_200,
    parameter int unsigned TimeoutClks    = 1_000_000,
    parameter bit          HoldOnReset    = 1'b1
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_ni,
    input  logic        uart_rx_i,
    output logic        host_req_o,
    input  logic        host_gnt_i,
    output logic [31:0] host_addr_o,
    output logic        host_we_o,
    output logic [3:0]  host_be_o,
    output logic [31:0] host_wdata_o,
    input  logic        host_rvalid_i,
    input  logic        host_err_i,
    output logic        hold_core_o,
    output logic [15:0] words_written_o,
    output logic        err_o
);

    localparam int unsigned ClksPerBit = ClockFrequency / BaudRate;
    localparam int unsigned HalfBit    = ClksPerBit / 2;
    localparam int unsigned BitCntW    = $clog2(ClksPerBit + 1);
    localparam int unsigned TmoW       = $clog2(TimeoutClks + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {P_SYNC, P_CMD, P_ADDR, P_DATA, P_BUS_REQ, P_BUS_WAIT} p_state_e;

    rx_state_e          rx_state_q, rx_state_d;
    logic               rx_meta, rx_sync;
    logic [BitCntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               byte_valid_q, byte_valid_d;
    logic               frame_err_q, frame_err_d;

    p_state_e           p_state_q, p_state_d;
    logic [1:0]         idx_q, idx_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic               req_q, req_d;
    logic [31:0]        haddr_q, haddr_d;
    logic [31:0]        hwdata_q, hwdata_d;
    logic               hold_q, hold_d;
    logic [15:0]        words_q, words_d;
    logic               err_q, err_d;
    logic               in_frame;

    // Two-flop synchroniser, idles high
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_data_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_data_q    <= rx_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Receiver: mid-bit sampling, LSB first
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_data_d    = rx_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == BitCntW'(HalfBit - 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BitCntW'(ClksPerBit - 1)) begin
                    rx_cnt_d  = '0;
                    rx_data_d = {rx_sync, rx_data_q[7:1]};
                    rx_bit_d  = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BitCntW'(ClksPerBit - 1)) begin
                    rx_cnt_d     = '0;
                    byte_valid_d = rx_sync;
                    frame_err_d  = !rx_sync;
                    rx_state_d   = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            p_state_q <= P_SYNC;
            idx_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            tmo_q     <= '0;
            req_q     <= 1'b0;
            haddr_q   <= '0;
            hwdata_q  <= '0;
            hold_q    <= HoldOnReset;
            words_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            p_state_q <= p_state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            tmo_q     <= tmo_d;
            req_q     <= req_d;
            haddr_q   <= haddr_d;
            hwdata_q  <= hwdata_d;
            hold_q    <= hold_d;
            words_q   <= words_d;
            err_q     <= err_d;
        end
    end

    assign in_frame = (p_state_q == P_CMD) || (p_state_q == P_ADDR) || (p_state_q == P_DATA);

    // Frame parser and bus host
    always_comb begin
        p_state_d = p_state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        tmo_d     = '0;
        req_d     = req_q;
        haddr_d   = haddr_q;
        hwdata_d  = hwdata_q;
        hold_d    = hold_q;
        words_d   = words_q;
        err_d     = 1'b0;
        case (p_state_q)
            P_SYNC: begin
                if (byte_valid_q && rx_data_q == 8'hA5) p_state_d = P_CMD;
            end
            P_CMD: begin
                if (byte_valid_q) begin
                    p_state_d = P_SYNC;
                    case (rx_data_q)
                        8'h01: begin
                            p_state_d = P_ADDR;
                            idx_d     = '0;
                        end
                        8'h02:   hold_d = 1'b0;
                        8'h03:   hold_d = 1'b1;
                        default: err_d  = 1'b1;
                    endcase
                end
            end
            P_ADDR: begin
                if (byte_valid_q) begin
                    addr_d[{idx_q, 3'b000} +: 8] = rx_data_q;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == 2'd3) p_state_d = P_DATA;
                end
            end
            P_DATA: begin
                if (byte_valid_q) begin
                    data_d[{idx_q, 3'b000} +: 8] = rx_data_q;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == 2'd3) begin
                        p_state_d = P_BUS_REQ;
                        req_d     = 1'b1;
                        haddr_d   = {addr_q[31:2], 2'b00};
                        hwdata_d  = data_d;
                    end
                end
            end
            P_BUS_REQ: begin
                if (host_gnt_i) begin
                    req_d     = 1'b0;
                    p_state_d = P_BUS_WAIT;
                end
            end
            P_BUS_WAIT: begin
                if (host_rvalid_i) begin
                    p_state_d = P_SYNC;
                    if (host_err_i) err_d = 1'b1;
                    else if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
                end
            end
            default: p_state_d = P_SYNC;
        endcase

        // Abandon a stalled partial frame
        if (in_frame && !byte_valid_q) begin
            if (tmo_q == TmoW'(TimeoutClks - 1)) begin
                err_d     = 1'b1;
                p_state_d = P_SYNC;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        // A pending bus transaction still completes on a framing error
        if (frame_err_q) begin
            err_d = 1'b1;
            if (p_state_q != P_BUS_REQ && p_state_q != P_BUS_WAIT) p_state_d = P_SYNC;
        end
    end

    assign host_req_o      = req_q;
    assign host_addr_o     = haddr_q;
    assign host_wdata_o    = hwdata_q;
    assign host_we_o       = 1'b1;
    assign host_be_o       = 4'hF;
    assign hold_core_o     = hold_q;
    assign words_written_o = words_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_uart_bus_loader.sv
// Randomised scoreboard bench for uart_bus_loader: frames are driven on the serial
// line, expected bus writes are queued and checked by a bus responder process.
module tb_uart_bus_loader;

    localparam int unsigned Cpb = 10;
    localparam int unsigned Tmo = 400;

    logic        clk_sys_i = 1'b0;
    logic        rst_sys_ni = 1'b0;
    logic        uart_rx_i = 1'b1;
    logic        host_req_o;
    logic        host_gnt_i;
    logic [31:0] host_addr_o;
    logic        host_we_o;
    logic [3:0]  host_be_o;
    logic [31:0] host_wdata_o;
    logic        host_rvalid_i;
    logic        host_err_i;
    logic        hold_core_o;
    logic [15:0] words_written_o;
    logic        err_o;

    uart_bus_loader #(
        .ClockFrequency(1_000_000),
        .BaudRate      (100_000),
        .TimeoutClks   (Tmo),
        .HoldOnReset   (1'b1)
    ) dut (
        .clk_sys_i      (clk_sys_i),
        .rst_sys_ni     (rst_sys_ni),
        .uart_rx_i      (uart_rx_i),
        .host_req_o     (host_req_o),
        .host_gnt_i     (host_gnt_i),
        .host_addr_o    (host_addr_o),
        .host_we_o      (host_we_o),
        .host_be_o      (host_be_o),
        .host_wdata_o   (host_wdata_o),
        .host_rvalid_i  (host_rvalid_i),
        .host_err_i     (host_err_i),
        .hold_core_o    (hold_core_o),
        .words_written_o(words_written_o),
        .err_o          (err_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          err;
        int          gnt_delay;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   err_seen = 0;
    int   exp_errs = 0;
    int   exp_words = 0;
    bit   exp_hold = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    always @(negedge clk_sys_i) if (err_o) err_seen++;

    // Bus responder and scoreboard monitor
    initial begin : responder
        txn_t        t;
        logic [31:0] a0;
        logic [31:0] d0;
        bit          aborted;
        host_gnt_i    = 1'b0;
        host_rvalid_i = 1'b0;
        host_err_i    = 1'b0;
        forever begin
            @(negedge clk_sys_i);
            if (host_req_o && rst_sys_ni) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 32'(host_req_o), 32'd0);
                    t.gnt_delay = 0;
                    t.err       = 1'b0;
                end else begin
                    t = exp_q.pop_front();
                    check("req_addr", host_addr_o, t.addr);
                    check("req_wdata", host_wdata_o, t.data);
                    check("req_be", 32'(host_be_o), 32'hF);
                    check("req_we", 32'(host_we_o), 32'd1);
                end
                a0 = host_addr_o;
                d0 = host_wdata_o;
                aborted = 1'b0;
                for (int i = 0; i < t.gnt_delay; i++) begin
                    @(negedge clk_sys_i);
                    if (!rst_sys_ni) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("req_held", 32'(host_req_o), 32'd1);
                    check("addr_stable", host_addr_o, a0);
                    check("wdata_stable", host_wdata_o, d0);
                end
                if (!aborted) begin
                    host_gnt_i = 1'b1;
                    @(negedge clk_sys_i);
                    host_gnt_i = 1'b0;
                    check("req_drop", 32'(host_req_o), 32'd0);
                    host_rvalid_i = 1'b1;
                    host_err_i    = t.err;
                    @(negedge clk_sys_i);
                    host_rvalid_i = 1'b0;
                    host_err_i    = 1'b0;
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_sys_i);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        uart_rx_i = 1'b0;
        wait_cycles(Cpb);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            wait_cycles(Cpb);
        end
        uart_rx_i = !bad_stop;
        wait_cycles(Cpb);
        uart_rx_i = 1'b1;
        wait_cycles(bad_stop ? 2 * Cpb : 2);
    endtask

    task automatic send_frame_bytes(input logic [31:0] addr, input logic [31:0] data);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], 1'b0);
        for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], 1'b0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input bit err,
                            input int gnt_delay);
        txn_t t;
        t.addr      = {addr[31:2], 2'b00};
        t.data      = data;
        t.err       = err;
        t.gnt_delay = gnt_delay;
        exp_q.push_back(t);
        send_frame_bytes(addr, data);
        wait_cycles(gnt_delay + 15);
        if (err) exp_errs++;
        else exp_words++;
        check("words_written", 32'(words_written_o), 32'(exp_words));
        check("err_count", 32'(err_seen), 32'(exp_errs));
        check("hold_after_write", 32'(hold_core_o), 32'(exp_hold));
    endtask

    task automatic do_hold_cmd(input bit run);
        send_byte(8'hA5, 1'b0);
        send_byte(run ? 8'h02 : 8'h03, 1'b0);
        wait_cycles(4);
        exp_hold = !run;
        check("hold_cmd", 32'(hold_core_o), 32'(exp_hold));
        check("err_count", 32'(err_seen), 32'(exp_errs));
    endtask

    function automatic logic [7:0] junk_byte();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        return b;
    endfunction

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit seen;
        int kind;
        wait_cycles(5);
        check("rst_req", 32'(host_req_o), 32'd0);
        check("rst_addr", host_addr_o, 32'd0);
        check("rst_wdata", host_wdata_o, 32'd0);
        check("rst_we", 32'(host_we_o), 32'd1);
        check("rst_be", 32'(host_be_o), 32'hF);
        check("rst_err", 32'(err_o), 32'd0);
        rst_sys_ni = 1'b1;
        wait_cycles(5);
        check("init_hold", 32'(hold_core_o), 32'd1);
        check("init_req", 32'(host_req_o), 32'd0);
        check("init_words", 32'(words_written_o), 32'd0);

        do_write(32'h0010_0000, 32'hDEAD_BEEF, 1'b0, 3);
        do_write(32'h0010_0003, 32'h4433_2211, 1'b1, 1);

        // Leading garbage is ignored before a RUN
        send_byte(8'h00, 1'b0);
        send_byte(8'h7F, 1'b0);
        send_byte(8'hA5, 1'b0);
        check("hold_before_run", 32'(hold_core_o), 32'd1);
        send_byte(8'h02, 1'b0);
        wait_cycles(4);
        exp_hold = 1'b0;
        check("hold_run", 32'(hold_core_o), 32'd0);
        do_hold_cmd(1'b0);

        // Framing error drops the byte
        send_byte(8'hA5, 1'b1);
        exp_errs++;
        send_byte(8'h02, 1'b0);
        wait_cycles(4);
        check("frame_err_count", 32'(err_seen), 32'(exp_errs));
        check("frame_err_hold", 32'(hold_core_o), 32'd1);

        // Unknown command
        send_byte(8'hA5, 1'b0);
        send_byte(8'h07, 1'b0);
        wait_cycles(4);
        exp_errs++;
        check("bad_cmd_err", 32'(err_seen), 32'(exp_errs));
        do_hold_cmd(1'b1);
        do_hold_cmd(1'b0);

        // Partial frame timeout
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_cycles(Tmo - 60);
        check("no_early_timeout", 32'(err_seen), 32'(exp_errs));
        wait_cycles(120);
        exp_errs++;
        check("timeout_err", 32'(err_seen), 32'(exp_errs));
        do_write($urandom, $urandom, 1'b0, 2);

        for (int n = 0; n < 10; n++) begin
            kind = $urandom_range(0, 9);
            if (kind == 7) do_hold_cmd(1'b1);
            else if (kind == 8) do_hold_cmd(1'b0);
            else begin
                if (kind == 9) begin
                    repeat ($urandom_range(1, 2)) send_byte(junk_byte(), 1'b0);
                end
                do_write($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 6));
            end
        end

        // Reset while a request is outstanding
        do_hold_cmd(1'b1);
        begin
            txn_t t;
            logic [31:0] ra;
            logic [31:0] rd;
            ra = $urandom;
            rd = $urandom;
            t.addr      = {ra[31:2], 2'b00};
            t.data      = rd;
            t.err       = 1'b0;
            t.gnt_delay = 50;
            exp_q.push_back(t);
            send_frame_bytes(ra, rd);
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_sys_i);
            seen = host_req_o;
        end
        check("req_before_reset", 32'(seen), 32'd1);
        wait_cycles(2);
        #2 rst_sys_ni = 1'b0;
        #1;
        check("reset_req_async", 32'(host_req_o), 32'd0);
        check("reset_hold", 32'(hold_core_o), 32'd1);
        check("reset_words", 32'(words_written_o), 32'd0);
        wait_cycles(3);
        rst_sys_ni = 1'b1;
        exp_hold  = 1'b1;
        exp_words = 0;
        wait_cycles(3);
        do_write(32'h0000_1234, 32'hCAFE_F00D, 1'b0, 0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
